// File: rtl/gpio_emu_pkg.sv
// rtl/gpio_emu_pkg.sv - shared address map and bit positions for the GPIO emulator
package gpio_emu_pkg;

   localparam logic [15:0] ADDR_AXIS1 = 16'h1094;
   localparam logic [15:0] ADDR_AXIS2 = 16'h1098;
   localparam logic [15:0] ADDR_CTRL  = 16'h109C;

   localparam int CTRL_EN_BIT    = 8;
   localparam int CTRL_GO_BIT    = 6;
   localparam int STATUS_RUN_BIT = 0;

   // Write-data fields that carry the axis setpoints
   localparam int AXIS1_LSB = 5;
   localparam int AXIS2_LSB = 7;

   typedef enum logic [1:0] {
      SEL_NONE  = 2'd0,
      SEL_AXIS1 = 2'd1,
      SEL_AXIS2 = 2'd2,
      SEL_CTRL  = 2'd3
   } reg_sel_e;

   // Map a bus address onto one of the three registers
   function automatic reg_sel_e decode_addr(input logic [15:0] addr,
                                            input logic [15:0] base);
      reg_sel_e sel;
      sel = SEL_NONE;
      if (addr == base)
         sel = SEL_AXIS1;
      else if (addr == base + 16'd4)
         sel = SEL_AXIS2;
      else if (addr == base + 16'd8)
         sel = SEL_CTRL;
      return sel;
   endfunction

endpackage

// File: rtl/gpio_emu_regs_if.sv
// rtl/gpio_emu_regs_if.sv - simple system bus bundle
interface gpio_emu_regs_if;

   logic [15:0] saddress;
   logic        srd;
   logic        swr;
   logic [31:0] sdata_in;
   logic [31:0] sdata_out;

   modport master (
      output saddress,
      output srd,
      output swr,
      output sdata_in,
      input  sdata_out
   );

   modport slave (
      input  saddress,
      input  srd,
      input  swr,
      input  sdata_in,
      output sdata_out
   );

endinterface

// File: rtl/gpio_emu_counter.sv
// rtl/gpio_emu_counter.sv - gated free-running cycle counter
module gpio_emu_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         n_reset,
   input  logic         run,
   output logic [W-1:0] cnt
);

   logic [W-1:0] r_cnt;

   // Count while enabled, hold otherwise; natural wrap at the top value
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset)
         r_cnt <= '0;
      else if (run)
         r_cnt <= r_cnt + 1'b1;
   end

   assign cnt = r_cnt;

endmodule

// File: rtl/gpio_emu_regs.sv
// rtl/gpio_emu_regs.sv - memory-mapped GPIO emulator register block
module gpio_emu_regs
   import gpio_emu_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = ADDR_AXIS1,
   parameter int          CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 n_reset,
   gpio_emu_regs_if.slave       bus,
   input  logic [31:0]          gpio_in,
   input  logic                 gpio_latch,
   output logic [31:0]          gpio_out
);

   logic [3:0]       r_axis1;
   logic [3:0]       r_axis2;
   logic             r_ctrl_en;
   logic             r_ctrl_go;
   logic [31:0]      r_gpio_in_s;
   logic [31:0]      r_sdata_out;

   logic             w_running;
   logic [CNT_W-1:0] w_cnt;
   reg_sel_e         w_sel;
   logic [31:0]      w_rd_data;
   logic             w_unused;

   assign w_sel     = decode_addr(bus.saddress, BASE_ADDR);
   assign w_running = r_ctrl_en & r_ctrl_go;

   gpio_emu_counter #(
      .W (CNT_W)
   ) u_counter (
      .clk     (clk),
      .n_reset (n_reset),
      .run     (w_running),
      .cnt     (w_cnt)
   );

   // Setpoint and control registers written from the bus
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_axis1   <= '0;
         r_axis2   <= '0;
         r_ctrl_en <= 1'b0;
         r_ctrl_go <= 1'b0;
      end else if (bus.swr) begin
         case (w_sel)
            SEL_AXIS1: r_axis1 <= bus.sdata_in[AXIS1_LSB +: 4];
            SEL_AXIS2: r_axis2 <= bus.sdata_in[AXIS2_LSB +: 4];
            SEL_CTRL: begin
               r_ctrl_en <= bus.sdata_in[CTRL_EN_BIT];
               r_ctrl_go <= bus.sdata_in[CTRL_GO_BIT];
            end
            default: ;
         endcase
      end
   end

   // Input pin snapshot taken only on the latch strobe
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset)
         r_gpio_in_s <= '0;
      else if (gpio_latch)
         r_gpio_in_s <= gpio_in;
   end

   // Read mux over current register contents; unmapped addresses read 0
   always_comb begin
      w_rd_data = '0;
      case (w_sel)
         SEL_AXIS1: w_rd_data = {28'b0, r_gpio_in_s[3:0]};
         SEL_AXIS2: w_rd_data = {28'b0, r_gpio_in_s[15:12]};
         SEL_CTRL: begin
            w_rd_data[31:16]          = w_cnt;
            w_rd_data[CTRL_EN_BIT]    = r_ctrl_en;
            w_rd_data[CTRL_GO_BIT]    = r_ctrl_go;
            w_rd_data[STATUS_RUN_BIT] = w_running;
         end
         default: w_rd_data = '0;
      endcase
   end

   // Registered read data; sampled before this edge's writes/latch take effect
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset)
         r_sdata_out <= '0;
      else if (bus.srd)
         r_sdata_out <= w_rd_data;
      else
         r_sdata_out <= '0;
   end

   assign bus.sdata_out = r_sdata_out;
   assign gpio_out      = {w_cnt, r_axis2, 8'b0, r_axis1};

   assign w_unused = &{1'b0, bus.sdata_in[31:11], bus.sdata_in[4:0],
                       r_gpio_in_s[31:16], r_gpio_in_s[11:4]};

endmodule

// File: tb/tb_gpio_emu_regs.sv
// tb/tb_gpio_emu_regs.sv - randomized and directed self-checking bench for gpio_emu_regs
module tb_gpio_emu_regs;

   logic        clk = 1'b0;
   logic        n_reset = 1'b0;
   logic [31:0] gpio_in = '0;
   logic        gpio_latch = 1'b0;
   logic [31:0] gpio_out;

   gpio_emu_regs_if bus ();

   gpio_emu_regs dut (
      .clk        (clk),
      .n_reset    (n_reset),
      .bus        (bus.slave),
      .gpio_in    (gpio_in),
      .gpio_latch (gpio_latch),
      .gpio_out   (gpio_out)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference state, kept as plain integers
   int unsigned m_axis1, m_axis2, m_en, m_go, m_cnt, m_gin, m_sdo;

   function automatic int unsigned m_read(input int unsigned addr);
      if (addr == 32'h1094) return m_gin % 16;
      if (addr == 32'h1098) return (m_gin / 4096) % 16;
      if (addr == 32'h109C) return m_cnt * 65536 + m_en * 256 + m_go * 64 + (m_en & m_go);
      return 0;
   endfunction

   function automatic int unsigned m_gpio_out();
      return m_cnt * 65536 + m_axis2 * 4096 + m_axis1;
   endfunction

   task automatic m_reset();
      m_axis1 = 0; m_axis2 = 0; m_en = 0; m_go = 0; m_cnt = 0; m_gin = 0; m_sdo = 0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One bus cycle: drive after falling edge, update model at rising edge, check just after
   task automatic step(input logic [15:0] addr, input logic rd, input logic wr,
                       input logic [31:0] din, input logic [31:0] gin, input logic latch);
      int unsigned was_running;
      @(negedge clk);
      bus.saddress = addr; bus.srd = rd; bus.swr = wr; bus.sdata_in = din;
      gpio_in = gin; gpio_latch = latch;
      @(posedge clk);
      was_running = m_en & m_go;
      m_sdo = rd ? m_read(addr) : 0;
      if (wr) begin
         if (addr == 16'h1094) m_axis1 = (din / 32) % 16;
         else if (addr == 16'h1098) m_axis2 = (din / 128) % 16;
         else if (addr == 16'h109C) begin
            m_en = (din / 256) % 2;
            m_go = (din / 64) % 2;
         end
      end
      if (latch) m_gin = gin;
      if (was_running != 0) m_cnt = (m_cnt + 1) % 65536;
      #1;
      check("sdata_out", bus.sdata_out, m_sdo);
      check("gpio_out", gpio_out, m_gpio_out());
   endtask

   task automatic idle();
      step(16'h0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   initial begin
      logic [15:0] cnt_a;
      logic [15:0] addrs [5];
      int          guard;
      addrs[0] = 16'h1094; addrs[1] = 16'h1098; addrs[2] = 16'h109C;
      addrs[3] = 16'h1090; addrs[4] = 16'h10A0;
      bus.saddress = '0; bus.srd = 1'b0; bus.swr = 1'b0; bus.sdata_in = '0;
      m_reset();

      // Reset state
      #12;
      check("rst_sdata_out", bus.sdata_out, 32'h0);
      check("rst_gpio_out", gpio_out, 32'h0);
      @(negedge clk); n_reset = 1'b1;
      step(16'h109C, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      check("rst_ctrl_read", bus.sdata_out, 32'h0);

      // Axis setpoints
      step(16'h1094, 1'b0, 1'b1, 32'h1E0, 32'h0, 1'b0);
      check("axis1_pins", {28'h0, gpio_out[3:0]}, 32'hF);
      step(16'h1098, 1'b0, 1'b1, 32'h780, 32'h0, 1'b0);
      check("axis2_pins", {28'h0, gpio_out[15:12]}, 32'hF);

      // Unmapped write and read
      step(16'h1090, 1'b0, 1'b1, 32'h7FF, 32'h0, 1'b0);
      check("unmapped_wr_pins", gpio_out, 32'h0000F00F);
      step(16'h1090, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      check("unmapped_rd", bus.sdata_out, 32'h0);

      // Input latch and feedback reads
      step(16'h0000, 1'b0, 1'b0, 32'h0, 32'h0000000F, 1'b1);
      step(16'h1094, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      check("fb_axis1", bus.sdata_out, 32'hF);
      step(16'h0000, 1'b0, 1'b0, 32'h0, 32'h0000F000, 1'b1);
      step(16'h1098, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      check("fb_axis2", bus.sdata_out, 32'hF);

      // Control stopped: counter static
      step(16'h109C, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
      step(16'h109C, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      check("ctrl_idle_read", bus.sdata_out, 32'h0);
      idle();
      check("cnt_static", {16'h0, gpio_out[31:16]}, 32'h0);

      // Start counting, watch increments and a full wrap
      step(16'h109C, 1'b0, 1'b1, 32'h140, 32'h0, 1'b0);
      cnt_a = gpio_out[31:16];
      idle();
      check("cnt_inc", {16'h0, gpio_out[31:16]}, {16'h0, cnt_a + 16'd1});
      step(16'h109C, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      check("ctrl_run_status", {16'h0, bus.sdata_out[15:0]}, 32'h0000_0141);
      guard = 0;
      while (gpio_out[31:16] !== 16'hFFFF && guard < 70000) begin
         idle();
         guard++;
      end
      check("cnt_reached_top", {16'h0, gpio_out[31:16]}, 32'h0000FFFF);
      idle();
      check("cnt_wrap", {16'h0, gpio_out[31:16]}, 32'h0);

      // Stop (GO=0): value held
      step(16'h109C, 1'b0, 1'b1, 32'h100, 32'h0, 1'b0);
      cnt_a = gpio_out[31:16];
      idle(); idle();
      check("cnt_hold", {16'h0, gpio_out[31:16]}, {16'h0, cnt_a});

      // Read and write together; latch and read together
      step(16'h1094, 1'b1, 1'b1, 32'h0A0, 32'h0, 1'b0);
      check("rw_same_rd", bus.sdata_out, 32'h0);
      check("rw_same_pins", {28'h0, gpio_out[3:0]}, 32'h5);
      step(16'h1094, 1'b1, 1'b0, 32'h0, 32'h0000_0003, 1'b1);
      check("latch_rd_old", bus.sdata_out, 32'h0);
      step(16'h1094, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      check("latch_rd_new", bus.sdata_out, 32'h3);

      // Randomized traffic against the model, with a reset in the middle
      for (int i = 0; i < 400; i++) begin
         step(addrs[$urandom_range(0, 4)], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom, $urandom, 1'($urandom_range(0, 1)));
         if (i == 200) begin
            step(16'h109C, 1'b0, 1'b1, 32'h140, 32'h0, 1'b0);
            idle(); idle();
            @(negedge clk); #2;
            n_reset = 1'b0;
            m_reset();
            #1;
            check("midrst_sdata_out", bus.sdata_out, 32'h0);
            check("midrst_gpio_out", gpio_out, 32'h0);
            @(negedge clk); n_reset = 1'b1;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
